// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared state type, stage width and reload helper for the counter-chain sequencer
package cnt_pkg;

  localparam int CNT_STAGE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } cnt_state_t;

  // Start value that makes an up counter of the given width overflow after n counts
  function automatic logic [31:0] reload_val(input logic [31:0] n, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (32'd0 - n) & mask;
  endfunction

endpackage

// File: rtl/cnt_reload_check.sv
// rtl/cnt_reload_check.sv - sticky plausibility checker for the counter chain contents
module cnt_reload_check #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cao,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  output logic             perr
);

  logic             chk_q;
  logic [WIDTH-1:0] exp_q;

  // The loaded value is remembered because the shadow may change on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q <= 1'b0;
      exp_q <= '0;
      perr  <= 1'b0;
    end else begin
      chk_q <= ld;
      exp_q <= d;
      if ((run && cao && (q != '1)) || (chk_q && (q != exp_q)))
        perr <= 1'b1;
    end
  end

endmodule

// File: rtl/cnt_reload_ctrl.sv
// rtl/cnt_reload_ctrl.sv - load/enable sequencer turning a cascaded up-counter chain into a divider
// Optional checker output PERR is built when CNT_RELOAD_CHECK_EN is defined.
module cnt_reload_ctrl
  import cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic             ONESHOT,
  input  logic [WIDTH-1:0] PERIOD,
  input  logic [WIDTH-1:0] Q,
  input  logic             CAO,
  output logic             LD,
  output logic [WIDTH-1:0] D,
  output logic             EN,
  output logic             CAI,
  output logic             TC,
  output logic             BUSY,
`ifdef CNT_RELOAD_CHECK_EN
  output logic             ERR,
  output logic             PERR
`else
  output logic             ERR
`endif
);

  if ((WIDTH % CNT_STAGE_W) != 0 || WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("cnt_reload_ctrl: WIDTH must be a multiple of 4 in 4..32");
  end

  cnt_state_t       state_q;
  logic [WIDTH-1:0] shadow_q;
  logic             oneshot_q;
  logic             ld_arm_q;
  logic             en_q;
  logic             tc_q;
  logic             busy_q;
  logic             err_q;

  logic [WIDTH-1:0] l_new;
  logic             period_nz;
  logic             reload;

  assign l_new     = WIDTH'(reload_val(32'(PERIOD), WIDTH));
  assign period_nz = (PERIOD != '0);
  assign reload    = (state_q == RUN) && CAO && !STOP;

  // STOP gates the chain in the same cycle so the counter holds where it stands
  assign LD   = (ld_arm_q && !STOP) || reload;
  assign EN   = en_q && !STOP;
  assign CAI  = en_q && !STOP;
  assign D    = shadow_q;
  assign TC   = tc_q;
  assign BUSY = busy_q;
  assign ERR  = err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      oneshot_q <= 1'b0;
      ld_arm_q  <= 1'b0;
      en_q      <= 1'b0;
      tc_q      <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (START && !STOP && period_nz) begin
            shadow_q  <= l_new;
            oneshot_q <= ONESHOT;
            ld_arm_q  <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ARM;
          end else if (START && !period_nz) begin
            err_q <= 1'b1;
          end
        end
        ARM: begin
          ld_arm_q <= 1'b0;
          if (STOP) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            en_q    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (STOP) begin
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (CAO) begin
            tc_q <= 1'b1;
            if (period_nz)
              shadow_q <= l_new;
            if (oneshot_q) begin
              en_q    <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          ld_arm_q <= 1'b0;
          en_q     <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

`ifdef CNT_RELOAD_CHECK_EN
  cnt_reload_check #(.WIDTH(WIDTH)) u_check (
    .clk  (CLK),
    .rst  (RST),
    .run  (state_q == RUN),
    .cao  (CAO),
    .ld   (LD),
    .d    (D),
    .q    (Q),
    .perr (PERR)
  );
`else
  logic unused_q;
  assign unused_q = ^Q;
`endif

endmodule

// File: tb/tb_cnt_reload_ctrl.sv
// tb/tb_cnt_reload_ctrl.sv - directed bench for cnt_reload_ctrl driving a behavioural 4-bit counter chain
module tb_cnt_reload_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       ONESHOT = 1'b0;
  logic [3:0] PERIOD = 4'd0;
  logic [3:0] Q;
  logic       CAO;
  logic       LD;
  logic [3:0] D;
  logic       EN;
  logic       CAI;
  logic       TC;
  logic       BUSY;
  logic       ERR;
`ifdef CNT_RELOAD_CHECK_EN
  logic       PERR;
`endif

  logic [3:0] mq = 4'd0;
  logic       force_en = 1'b0;
  logic [3:0] force_val = 4'd0;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  // Counter chain: LD has priority over counting; carry out when counting through all-ones
  always @(posedge CLK) begin
    if (LD) mq <= D;
    else if (EN && CAI) mq <= mq + 4'd1;
  end
  assign CAO = CAI && (mq == 4'hF);
  assign Q   = force_en ? force_val : mq;

  cnt_reload_ctrl #(.WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .ONESHOT(ONESHOT),
    .PERIOD(PERIOD), .Q(Q), .CAO(CAO), .LD(LD), .D(D), .EN(EN), .CAI(CAI),
    .TC(TC), .BUSY(BUSY),
`ifdef CNT_RELOAD_CHECK_EN
    .ERR(ERR), .PERR(PERR)
`else
    .ERR(ERR)
`endif
  );

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    checks++; if ({LD, EN, CAI, TC, BUSY, ERR} !== 6'b0) begin failures++; $display("FAIL reset_outs got=%b exp=000000", {LD, EN, CAI, TC, BUSY, ERR}); end
    checks++; if (D !== 4'd0) begin failures++; $display("FAIL reset_d got=%0d exp=0", D); end
`ifdef CNT_RELOAD_CHECK_EN
    checks++; if (PERR !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", PERR); end
`endif
  endtask

  task automatic test_continuous();
    PERIOD = 4'd5; ONESHOT = 1'b0; START = 1'b1;
    tick();
    checks++; if (LD !== 1'b1) begin failures++; $display("FAIL cont_arm_ld got=%b exp=1", LD); end
    checks++; if (EN !== 1'b0) begin failures++; $display("FAIL cont_arm_en got=%b exp=0", EN); end
    checks++; if (D !== 4'd11) begin failures++; $display("FAIL cont_arm_d got=%0d exp=11", D); end
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL cont_arm_busy got=%b exp=1", BUSY); end
    tick();
    for (int k = 0; k < 15; k++) begin
      checks++; if (Q !== 4'(11 + k % 5)) begin failures++; $display("FAIL cont_q k=%0d got=%0d exp=%0d", k, Q, 11 + k % 5); end
      checks++; if (LD !== (k % 5 == 4)) begin failures++; $display("FAIL cont_ld k=%0d got=%b exp=%b", k, LD, (k % 5 == 4)); end
      checks++; if (TC !== (k > 0 && k % 5 == 0)) begin failures++; $display("FAIL cont_tc k=%0d got=%b exp=%b", k, TC, (k > 0 && k % 5 == 0)); end
      tick();
    end
    START = 1'b0; STOP = 1'b1;
    #1;
    checks++; if (EN !== 1'b0) begin failures++; $display("FAIL cont_stop_en got=%b exp=0", EN); end
    tick();
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL cont_stop_busy got=%b exp=0", BUSY); end
    STOP = 1'b0;
  endtask

  task automatic test_oneshot();
    int tcs;
    PERIOD = 4'd3; ONESHOT = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    checks++; if (Q !== 4'd13) begin failures++; $display("FAIL one_q0 got=%0d exp=13", Q); end
    tick();
    tick();
    checks++; if (LD !== 1'b1 || BUSY !== 1'b1) begin failures++; $display("FAIL one_cao ld_busy got=%b%b exp=11", LD, BUSY); end
    tick();
    checks++; if (TC !== 1'b1) begin failures++; $display("FAIL one_tc got=%b exp=1", TC); end
    checks++; if (BUSY !== 1'b0 || EN !== 1'b0) begin failures++; $display("FAIL one_idle busy_en got=%b%b exp=00", BUSY, EN); end
    checks++; if (Q !== 4'd13) begin failures++; $display("FAIL one_rest_q got=%0d exp=13", Q); end
    tcs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (TC === 1'b1) tcs++;
    end
    checks++; if (tcs !== 0) begin failures++; $display("FAIL one_extra_tc got=%0d exp=0", tcs); end
    checks++; if (Q !== 4'd13) begin failures++; $display("FAIL one_hold_q got=%0d exp=13", Q); end
    ONESHOT = 1'b0;
  endtask

  task automatic test_err();
    PERIOD = 4'd0; START = 1'b1;
    tick();
    checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", ERR); end
    checks++; if (BUSY !== 1'b0 || LD !== 1'b0) begin failures++; $display("FAIL err_idle busy_ld got=%b%b exp=00", BUSY, LD); end
    START = 1'b0;
    tick();
    tick();
    checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", ERR); end
    PERIOD = 4'd5; RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", ERR); end
  endtask

  task automatic test_stop_on_cao();
    PERIOD = 4'd4; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    checks++; if (Q !== 4'd12) begin failures++; $display("FAIL stop_q0 got=%0d exp=12", Q); end
    tick(); tick(); tick();
    checks++; if (CAO !== 1'b1) begin failures++; $display("FAIL stop_cao_seen got=%b exp=1", CAO); end
    STOP = 1'b1;
    #1;
    checks++; if (LD !== 1'b0 || EN !== 1'b0) begin failures++; $display("FAIL stop_ld_en got=%b%b exp=00", LD, EN); end
    tick();
    checks++; if (TC !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL stop_tc_busy got=%b%b exp=00", TC, BUSY); end
    checks++; if (Q !== 4'd15) begin failures++; $display("FAIL stop_q got=%0d exp=15", Q); end
    STOP = 1'b0;
    tick();
    checks++; if (Q !== 4'd15 || TC !== 1'b0) begin failures++; $display("FAIL stop_hold q=%0d tc=%b exp q=15 tc=0", Q, TC); end
  endtask

  task automatic test_period_change();
    int tc_idx [20];
    int n;
    PERIOD = 4'd5; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    PERIOD = 4'd2;
    n = 0;
    for (int i = 0; i < 20; i++) tc_idx[i] = 0;
    for (int k = 0; k < 20; k++) begin
      if (TC === 1'b1 && n < 20) begin tc_idx[n] = k; n++; end
      tick();
    end
    checks++; if (n < 5) begin failures++; $display("FAIL chg_tc_count got=%0d exp>=5", n); end
    checks++; if (tc_idx[0] !== 5) begin failures++; $display("FAIL chg_first_tc got=%0d exp=5", tc_idx[0]); end
    checks++; if (tc_idx[3] - tc_idx[2] !== 2) begin failures++; $display("FAIL chg_gap_a got=%0d exp=2", tc_idx[3] - tc_idx[2]); end
    checks++; if (tc_idx[4] - tc_idx[3] !== 2) begin failures++; $display("FAIL chg_gap_b got=%0d exp=2", tc_idx[4] - tc_idx[3]); end
    PERIOD = 4'd1;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (D !== 4'd15) begin failures++; $display("FAIL n1_d got=%0d exp=15", D); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (TC !== 1'b1) begin failures++; $display("FAIL n1_tc i=%0d got=%b exp=1", i, TC); end
      tick();
    end
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
  endtask

`ifdef CNT_RELOAD_CHECK_EN
  task automatic test_perr();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    PERIOD = 4'd3; START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    checks++; if (PERR !== 1'b0) begin failures++; $display("FAIL perr_clean got=%b exp=0", PERR); end
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
    force_en = 1'b1; force_val = 4'd9;
    tick();
    tick();
    checks++; if (PERR !== 1'b1) begin failures++; $display("FAIL perr_set got=%b exp=1", PERR); end
    force_en = 1'b0;
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_oneshot();
    test_err();
    test_stop_on_cao();
    test_period_change();
`ifdef CNT_RELOAD_CHECK_EN
    test_perr();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
